// File: rtl/vproc_result_pack.sv
// rtl/vproc_result_pack.sv - packs result beats (optionally narrowed) into whole vector register writes
//
// Purpose: collects RES_W-bit result beats into a VREG_W-bit write. A beat can
// first be narrowed from 2*EEW-bit to EEW-bit elements, with truncation or
// signed/unsigned saturation. The write is emitted when the register is full
// or when a beat is marked last.
// Ports:
//   clk_i, async_rst_i            clock and asynchronous active-high reset
//   in_valid_i / in_ready_o       result beat handshake (ready only while filling)
//   in_res_i, in_mask_i           beat data and per-output-byte enables
//   in_eew_i, in_narrow_i,
//   in_saturate_i, in_sig_i       narrowing controls
//   in_vaddr_i, in_last_i         destination register and force-flush
//   out_valid_o / out_ready_i     vreg write handshake
//   out_vaddr_o, out_data_o,
//   out_be_o                      vreg write address, data and byte enables
//   busy_o                        partial or pending data is held
module vproc_result_pack #(
    parameter int VREG_W = 128,
    parameter int RES_W  = 32
) (
    input  logic                  clk_i,
    input  logic                  async_rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [RES_W-1:0]      in_res_i,
    input  logic [RES_W/8-1:0]    in_mask_i,
    input  logic [1:0]            in_eew_i,
    input  logic                  in_narrow_i,
    input  logic                  in_saturate_i,
    input  logic                  in_sig_i,
    input  logic [4:0]            in_vaddr_i,
    input  logic                  in_last_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [4:0]            out_vaddr_o,
    output logic [VREG_W-1:0]     out_data_o,
    output logic [VREG_W/8-1:0]   out_be_o,
    output logic                  busy_o
);
    localparam int POS_MAX = 2 * VREG_W / RES_W;
    localparam int POS_W   = $clog2(POS_MAX + 3);
    localparam int HBYTES  = RES_W / 16;   // bytes per pos unit (half a beat)
    localparam int VBYTES  = VREG_W / 8;

    typedef enum logic {FILL = 1'b0, FLUSH = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic [4:0]          vaddr_q, vaddr_d;
    logic [VREG_W-1:0]   data_q, data_d;
    logic [VBYTES-1:0]   be_q, be_d;

    logic                eff_narrow;
    logic [RES_W/2-1:0]  nar8, nar16;
    logic [RES_W-1:0]    src;
    int                  nbytes;
    int                  idx;

    // 16 -> 8 bit element reduction
    function automatic logic [7:0] red8(input logic [15:0] e, input logic sat, input logic sig);
        if (!sat) return e[7:0];
        if (sig) begin
            if (!e[15] && (e[14:7] != 8'h00)) return 8'h7F;
            if (e[15] && (e[14:7] != 8'hFF)) return 8'h80;
            return e[7:0];
        end
        if (e[15:8] != 8'h00) return 8'hFF;
        return e[7:0];
    endfunction

    // 32 -> 16 bit element reduction
    function automatic logic [15:0] red16(input logic [31:0] e, input logic sat, input logic sig);
        if (!sat) return e[15:0];
        if (sig) begin
            if (!e[31] && (e[30:15] != 16'h0000)) return 16'h7FFF;
            if (e[31] && (e[30:15] != 16'hFFFF)) return 16'h8000;
            return e[15:0];
        end
        if (e[31:16] != 16'h0000) return 16'hFFFF;
        return e[15:0];
    endfunction

    // Only 8- and 16-bit destinations can be narrowed into; other widths pass through.
    assign eff_narrow = in_narrow_i && ((in_eew_i == 2'd0) || (in_eew_i == 2'd1));

    always_comb begin
        nar8  = '0;
        nar16 = '0;
        for (int k = 0; k < RES_W / 16; k++) begin
            nar8[k*8 +: 8] = red8(in_res_i[k*16 +: 16], in_saturate_i, in_sig_i);
        end
        for (int k = 0; k < RES_W / 32; k++) begin
            nar16[k*16 +: 16] = red16(in_res_i[k*32 +: 32], in_saturate_i, in_sig_i);
        end
    end

    always_comb begin
        src = in_res_i;
        if (eff_narrow) begin
            src = {{(RES_W/2){1'b0}}, (in_eew_i == 2'd0) ? nar8 : nar16};
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        vaddr_d = vaddr_q;
        data_d  = data_q;
        be_d    = be_q;
        nbytes  = eff_narrow ? HBYTES : 2 * HBYTES;
        idx     = 0;
        if (state_q == FILL) begin
            if (in_valid_i) begin
                if (pos_q == '0) vaddr_d = in_vaddr_i;
                for (int j = 0; j < RES_W / 8; j++) begin
                    idx = int'(pos_q) * HBYTES + j;
                    if ((j < nbytes) && (idx < VBYTES) && in_mask_i[j]) begin
                        data_d[idx*8 +: 8] = src[j*8 +: 8];
                        be_d[idx]          = 1'b1;
                    end
                end
                pos_d = pos_q + (eff_narrow ? POS_W'(1) : POS_W'(2));
                if ((pos_d >= POS_W'(POS_MAX)) || in_last_i) state_d = FLUSH;
            end
        end else if (out_ready_i) begin
            state_d = FILL;
            pos_d   = '0;
            data_d  = '0;
            be_d    = '0;
        end
    end

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            state_q <= FILL;
            pos_q   <= '0;
            vaddr_q <= '0;
            data_q  <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            vaddr_q <= vaddr_d;
            data_q  <= data_d;
            be_q    <= be_d;
        end
    end

    assign in_ready_o  = (state_q == FILL);
    assign out_valid_o = (state_q == FLUSH);
    assign out_vaddr_o = vaddr_q;
    assign out_data_o  = data_q;
    assign out_be_o    = be_q;
    assign busy_o      = (state_q == FLUSH) || (pos_q != '0);

endmodule

// File: tb/tb_vproc_result_pack.sv
// tb/tb_vproc_result_pack.sv - directed self-checking bench for vproc_result_pack
module tb_vproc_result_pack;
    logic         clk_i = 1'b0;
    logic         async_rst_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [31:0]  in_res_i;
    logic [3:0]   in_mask_i;
    logic [1:0]   in_eew_i;
    logic         in_narrow_i;
    logic         in_saturate_i;
    logic         in_sig_i;
    logic [4:0]   in_vaddr_i;
    logic         in_last_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [4:0]   out_vaddr_o;
    logic [127:0] out_data_o;
    logic [15:0]  out_be_o;
    logic         busy_o;

    int checks   = 0;
    int failures = 0;

    logic [127:0] held_data;
    logic [15:0]  held_be;

    vproc_result_pack #(.VREG_W(128), .RES_W(32)) dut (
        .clk_i(clk_i), .async_rst_i(async_rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_res_i(in_res_i), .in_mask_i(in_mask_i), .in_eew_i(in_eew_i),
        .in_narrow_i(in_narrow_i), .in_saturate_i(in_saturate_i), .in_sig_i(in_sig_i),
        .in_vaddr_i(in_vaddr_i), .in_last_i(in_last_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_vaddr_o(out_vaddr_o), .out_data_o(out_data_o), .out_be_o(out_be_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one beat for one clock; called away from the clock edge.
    task automatic beat(input logic [31:0] res, input logic [3:0] mask, input logic [1:0] eew,
                        input logic narrow, input logic sat, input logic sig,
                        input logic [4:0] va, input logic last);
        in_valid_i    = 1'b1;
        in_res_i      = res;
        in_mask_i     = mask;
        in_eew_i      = eew;
        in_narrow_i   = narrow;
        in_saturate_i = sat;
        in_sig_i      = sig;
        in_vaddr_i    = va;
        in_last_i     = last;
        check("beat_in_ready", 128'(in_ready_o), 128'd1);
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    // Complete the pending write, then confirm the block is empty again.
    task automatic drain(input string tag);
        check({tag, "_valid"}, 128'(out_valid_o), 128'd1);
        out_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b0;
        check({tag, "_post_valid"}, 128'(out_valid_o), 128'd0);
        check({tag, "_post_ready"}, 128'(in_ready_o), 128'd1);
        check({tag, "_post_busy"}, 128'(busy_o), 128'd0);
        check({tag, "_post_data"}, out_data_o, 128'd0);
        check({tag, "_post_be"}, 128'(out_be_o), 128'd0);
    endtask

    initial begin
        async_rst_i = 1'b1;
        in_valid_i = 1'b0; in_res_i = '0; in_mask_i = '0; in_eew_i = '0;
        in_narrow_i = 1'b0; in_saturate_i = 1'b0; in_sig_i = 1'b0;
        in_vaddr_i = '0; in_last_i = 1'b0; out_ready_i = 1'b0;
        #3;
        check("rst_valid", 128'(out_valid_o), 128'd0);
        check("rst_ready", 128'(in_ready_o), 128'd1);
        check("rst_busy", 128'(busy_o), 128'd0);
        check("rst_data", out_data_o, 128'd0);
        check("rst_be", 128'(out_be_o), 128'd0);
        check("rst_vaddr", 128'(out_vaddr_o), 128'd0);
        @(negedge clk_i);
        async_rst_i = 1'b0;
        @(negedge clk_i);

        // Full register of non-narrow beats; later vaddr values must be ignored.
        beat(32'h11111111, 4'hF, 2'd2, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0);
        check("full_busy1", 128'(busy_o), 128'd1);
        check("full_nvalid1", 128'(out_valid_o), 128'd0);
        beat(32'h22222222, 4'hF, 2'd2, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0);
        beat(32'h33333333, 4'hF, 2'd2, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0);
        check("full_nvalid3", 128'(out_valid_o), 128'd0);
        beat(32'h44444444, 4'hF, 2'd2, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0);
        check("full_data", out_data_o, 128'h44444444_33333333_22222222_11111111);
        check("full_be", 128'(out_be_o), 128'hFFFF);
        check("full_vaddr", 128'(out_vaddr_o), 128'd5);
        check("full_ready", 128'(in_ready_o), 128'd0);
        drain("full");

        // EEW8 signed saturate: 0x0100 -> 0x7F, 0xFF00 -> 0x80.
        beat(32'hFF000100, 4'hF, 2'd0, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1);
        check("s8_data", out_data_o, 128'h807F);
        check("s8_be", 128'(out_be_o), 128'h0003);
        check("s8_vaddr", 128'(out_vaddr_o), 128'd3);
        drain("s8");

        // EEW8 unsigned: saturate clamps 0x100 to 0xFF, truncate gives 0x00.
        beat(32'h00000100, 4'hF, 2'd0, 1'b1, 1'b1, 1'b0, 5'd1, 1'b1);
        check("u8sat_data", out_data_o, 128'h00FF);
        drain("u8sat");
        beat(32'h00000100, 4'hF, 2'd0, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1);
        check("u8trunc_data", out_data_o, 128'h0000);
        check("u8trunc_be", 128'(out_be_o), 128'h0003);
        drain("u8trunc");

        // EEW16 narrowing of 0x00018000: saturate -> 0x7FFF, truncate -> 0x8000.
        beat(32'h00018000, 4'hF, 2'd1, 1'b1, 1'b1, 1'b1, 5'd2, 1'b1);
        check("s16_data", out_data_o, 128'h7FFF);
        drain("s16");
        beat(32'h00018000, 4'hF, 2'd1, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1);
        check("t16_data", out_data_o, 128'h8000);
        drain("t16");

        // Narrow request with 32-bit EEW is a plain beat.
        beat(32'h12345678, 4'hF, 2'd2, 1'b1, 1'b1, 1'b1, 5'd4, 1'b1);
        check("e32_data", out_data_o, 128'h12345678);
        check("e32_be", 128'(out_be_o), 128'h000F);
        drain("e32");

        // Two narrow beats advance pos by one half-beat each.
        beat(32'h00340012, 4'hF, 2'd0, 1'b1, 1'b0, 1'b0, 5'd6, 1'b0);
        check("nn_busy", 128'(busy_o), 128'd1);
        beat(32'h00780056, 4'hF, 2'd0, 1'b1, 1'b0, 1'b0, 5'd7, 1'b1);
        check("nn_data", out_data_o, 128'h78563412);
        check("nn_be", 128'(out_be_o), 128'h000F);
        check("nn_vaddr", 128'(out_vaddr_o), 128'd6);
        drain("nn");

        // Partial mask with last, then back-pressure for three cycles.
        beat(32'hAABBCCDD, 4'h3, 2'd2, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1);
        check("pm_data", out_data_o, 128'h0000CCDD);
        check("pm_be", 128'(out_be_o), 128'h0003);
        check("pm_busy", 128'(busy_o), 128'd1);
        held_data = out_data_o;
        held_be   = out_be_o;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            check("bp_valid", 128'(out_valid_o), 128'd1);
            check("bp_ready", 128'(in_ready_o), 128'd0);
            check("bp_data", out_data_o, held_data);
            check("bp_be", 128'(out_be_o), 128'(held_be));
            check("bp_vaddr", 128'(out_vaddr_o), 128'd8);
        end
        drain("pm");

        // Last beat with no enables still flushes an empty write.
        beat(32'hCAFEF00D, 4'h0, 2'd2, 1'b0, 1'b0, 1'b0, 5'd10, 1'b1);
        check("empty_data", out_data_o, 128'd0);
        check("empty_be", 128'(out_be_o), 128'd0);
        drain("empty");

        // Reset pulse in FLUSH drops the write immediately.
        beat(32'h55555555, 4'hF, 2'd2, 1'b0, 1'b0, 1'b0, 5'd11, 1'b1);
        check("rf_valid_pre", 128'(out_valid_o), 128'd1);
        #2;
        async_rst_i = 1'b1;
        #1;
        check("rf_valid", 128'(out_valid_o), 128'd0);
        check("rf_busy", 128'(busy_o), 128'd0);
        check("rf_data", out_data_o, 128'd0);
        @(negedge clk_i);
        async_rst_i = 1'b0;
        beat(32'hDEADBEEF, 4'hF, 2'd2, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1);
        check("rf_after_data", out_data_o, 128'hDEADBEEF);
        check("rf_after_vaddr", 128'(out_vaddr_o), 128'd7);
        drain("rf");

        // Reset mid-FILL discards the partial beat.
        beat(32'h99999999, 4'hF, 2'd2, 1'b0, 1'b0, 1'b0, 5'd12, 1'b0);
        #2;
        async_rst_i = 1'b1;
        #1;
        check("rm_busy", 128'(busy_o), 128'd0);
        @(negedge clk_i);
        async_rst_i = 1'b0;
        beat(32'h01020304, 4'hF, 2'd2, 1'b0, 1'b0, 1'b0, 5'd13, 1'b1);
        check("rm_data", out_data_o, 128'h01020304);
        check("rm_be", 128'(out_be_o), 128'h000F);
        check("rm_vaddr", 128'(out_vaddr_o), 128'd13);
        drain("rm");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vproc_result_pack.md
VPROC_RESULT_PACK -- requirements
Module: vproc_result_pack

Interface
REQ-001 The block SHALL have parameter VREG_W, default 128, vector register width in bits (multiple of 2*RES_W).
REQ-002 The block SHALL have parameter RES_W, default 32, result beat width in bits (multiple of 16).
REQ-003 The block SHALL have one clock and one reset: reset is asynchronous and active-high, ports clk_i (rising edge) and async_rst_i.
REQ-004 The block SHALL have the following ports:
- clk_i  in  1  clock
- async_rst_i  in  1  asynchronous active-high reset
- in_valid_i  in  1  result beat valid
- in_ready_o  out  1  result beat accepted
- in_res_i  in  RES_W  result data
- in_mask_i  in  RES_W/8  per-output-byte write enable
- in_eew_i  in  2  cfg_vsew, destination element width
- in_narrow_i  in  1  beat holds 2*EEW elements to be narrowed
- in_saturate_i  in  1  saturate when narrowing
- in_sig_i  in  1  narrowed elements are signed
- in_vaddr_i  in  5  destination vreg
- in_last_i  in  1  final beat, force flush
- out_valid_o  out  1  vreg write valid
- out_ready_i  in  1  vreg write accepted
- out_vaddr_o  out  5  vreg write address
- out_data_o  out  VREG_W  vreg write data
- out_be_o  out  VREG_W/8  vreg byte enables
- busy_o  out  1  partial or pending data held

Function
REQ-005 Two states SHALL exist: FILL and FLUSH; in_ready_o SHALL be 1 exactly in FILL, and out_valid_o SHALL be 1 exactly in FLUSH.
REQ-006 A write position counter pos SHALL count in RES_W/2-bit units, range 0..2*VREG_W/RES_W.
REQ-007 A non-narrow beat SHALL write RES_W bits at bit offset pos*RES_W/2, byte i enabled by in_mask_i[i], and SHALL advance pos by 2.
REQ-008 A narrow beat SHALL write RES_W/2 bits at the same offset and SHALL advance pos by 1.
- Narrow beat content: RES_W/(2*EEW) elements of 2*EEW bits each, every element reduced to EEW bits.
- Byte enables: in_mask_i[RES_W/16-1:0]; upper mask bits ignored.
REQ-009 Narrowing SHALL use EEW = 8 or 16 only; in_narrow_i with VSEW_32 SHALL be treated as a non-narrow beat.
REQ-010 Reduction without saturate SHALL truncate each element to its low EEW bits.
REQ-011 Saturate with in_sig_i=1 SHALL clamp to [-2^(EEW-1), 2^(EEW-1)-1].
REQ-012 Saturate with in_sig_i=0 SHALL treat the input element as unsigned and clamp it to 2^EEW-1.
REQ-013 The first beat accepted with pos==0 SHALL latch in_vaddr_i into out_vaddr_o; in_vaddr_i of later beats SHALL be ignored until the next flush.
REQ-014 Enable handling SHALL be:
- out_be_o bit SHALL be set when its byte is written with an enable.
- Bytes never enabled since the last flush SHALL read 0 in out_data_o and out_be_o.
- Re-writing an enabled byte SHALL overwrite its data.
REQ-015 On an accepted beat, FILL SHALL go to FLUSH when the updated pos equals 2*VREG_W/RES_W or in_last_i=1; out_valid_o SHALL rise the cycle after acceptance (latency 1).
REQ-016 In FLUSH, out_vaddr_o, out_data_o and out_be_o SHALL hold stable while out_ready_i=0.
REQ-017 The cycle after out_valid_o&&out_ready_i, the block SHALL be in FILL with pos=0, data=0 and out_be_o=0.
REQ-018 in_last_i on a beat with all enables 0 SHALL still flush (out_be_o all 0 allowed).
REQ-019 Beats within one flush SHALL share the same in_narrow_i; mixed sequences are outside contract.
REQ-020 busy_o SHALL equal (state==FLUSH) || (pos!=0).

Reset
REQ-021 While async_rst_i=1, independent of clk_i:
- state SHALL be FILL and pos 0.
- out_valid_o SHALL be 0 and busy_o 0.
- out_vaddr_o, out_data_o and out_be_o SHALL be 0.
- in_ready_o SHALL be 1.
REQ-022 Reset asserted in FLUSH SHALL discard the pending write without a handshake.
REQ-023 Reset asserted mid-FILL SHALL discard partial data.

Verification (VREG_W=128, RES_W=32)
REQ-024 Four non-narrow beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 with mask 0xF and vaddr 5 -> next cycle: out_valid_o=1, data 0x44444444_33333333_22222222_11111111, out_be_o 0xFFFF, out_vaddr_o 5.
REQ-025 Narrow EEW8 signed saturating beat res 0xFF00_0100 with in_last_i=1 -> data[15:0]=0x807F, out_be_o 0x0003.
REQ-026 Narrow EEW8 unsigned beat res 0x0000_0100 with in_last_i=1 -> saturate gives data[7:0]=0xFF; no saturate gives data[7:0]=0x00.
REQ-027 One beat 0xAABBCCDD with mask 0x3 and in_last_i=1 -> data 0x...0000CCDD, out_be_o 0x0003; busy_o drops after the handshake.
REQ-028 out_ready_i held 0 for 3 cycles in FLUSH -> outputs stable and in_ready_o=0 throughout; on handshake the next cycle is FILL with pos=0.
REQ-029 async_rst_i pulsed in FLUSH -> out_valid_o=0 immediately; subsequent beats start at pos 0.
